// File: rtl/icap_word_packer.sv
// Pops configuration bytes from the async FIFO, hunts for the sync word, then packs
// big-endian 32-bit words onto the ICAP port. Optional ICAP_BITSWAP_EN bit-reverses each output byte.
module icap_word_packer #(
  parameter int          DATA_SIZE = 8,
  parameter logic [31:0] SYNC_WORD = 32'hAA995566,
  parameter int          WCNT_W    = 24
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] rdata,
  input  logic                 rempty,
  output logic                 rinc,
  output logic                 icap_csib,
  output logic                 icap_rdwrb,
  output logic [31:0]          icap_i,
  output logic                 synced,
  output logic                 desync_done,
  output logic [WCNT_W-1:0]    word_cnt
);

  localparam logic [31:0] CMD_WORD    = 32'h30008001;
  localparam logic [31:0] DESYNC_WORD = 32'h0000000D;

  typedef enum logic {
    SEARCH = 1'b0,
    PACK   = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] sr_r, sr_nxt_s;
  logic [1:0]  bc_r, bc_nxt_s;
  logic        cmd_seen_r, cmd_nxt_s;
  logic        synced_nxt_s;
  logic        issue_s;
  logic        desync_s;
  logic [31:0] shifted_s;
  logic [31:0] out_word_s;

`ifdef ICAP_BITSWAP_EN
  function automatic logic [31:0] lane_swap(input logic [31:0] w);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) begin
        r[8*i+j] = w[8*i+7-j];
      end
    end
    return r;
  endfunction

  assign out_word_s = lane_swap(shifted_s);
`else
  assign out_word_s = shifted_s;
`endif

  assign rinc      = en & ~rempty & ~rrst;
  assign shifted_s = {sr_r[23:0], rdata};

  // Next-state, shift register, byte counter and issue decisions
  always_comb begin
    state_nxt_s  = state_r;
    sr_nxt_s     = sr_r;
    bc_nxt_s     = bc_r;
    cmd_nxt_s    = cmd_seen_r;
    synced_nxt_s = synced;
    issue_s      = 1'b0;
    desync_s     = 1'b0;
    if (rinc) begin
      sr_nxt_s = shifted_s;
      case (state_r)
        SEARCH: begin
          if (shifted_s == SYNC_WORD) begin
            issue_s      = 1'b1;
            synced_nxt_s = 1'b1;
            bc_nxt_s     = 2'd0;
            state_nxt_s  = PACK;
            cmd_nxt_s    = 1'b0;
          end else begin
            bc_nxt_s = bc_r;
          end
        end
        PACK: begin
          bc_nxt_s = bc_r + 2'd1;
          if (bc_r == 2'd3) begin
            issue_s   = 1'b1;
            cmd_nxt_s = (shifted_s == CMD_WORD);
            // DESYNC only counts when the command-register write immediately preceded it
            if ((shifted_s == DESYNC_WORD) && cmd_seen_r) begin
              desync_s     = 1'b1;
              synced_nxt_s = 1'b0;
              sr_nxt_s     = 32'h0000_0000;
              bc_nxt_s     = 2'd0;
              state_nxt_s  = SEARCH;
            end else begin
              desync_s = 1'b0;
            end
          end else begin
            issue_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = SEARCH;
        end
      endcase
    end else begin
      issue_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_r <= SEARCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers and registered ICAP outputs
  always_ff @(posedge rclk) begin
    if (rrst) begin
      sr_r        <= 32'h0000_0000;
      bc_r        <= 2'd0;
      cmd_seen_r  <= 1'b0;
      synced      <= 1'b0;
      desync_done <= 1'b0;
      icap_csib   <= 1'b1;
      icap_rdwrb  <= 1'b1;
      icap_i      <= 32'h0000_0000;
      word_cnt    <= {WCNT_W{1'b0}};
    end else begin
      sr_r        <= sr_nxt_s;
      bc_r        <= bc_nxt_s;
      cmd_seen_r  <= cmd_nxt_s;
      synced      <= synced_nxt_s;
      desync_done <= desync_s;
      icap_csib   <= ~issue_s;
      icap_rdwrb  <= ~issue_s;
      if (issue_s) begin
        icap_i   <= out_word_s;
        word_cnt <= word_cnt + {{(WCNT_W-1){1'b0}}, 1'b1};
      end else begin
        icap_i   <= icap_i;
        word_cnt <= word_cnt;
      end
    end
  end

endmodule

// File: tb/tb_icap_word_packer.sv
// Self-checking bench for icap_word_packer: directed segments plus randomized en/rempty,
// compared cycle by cycle against a byte-stream reference model. Honours ICAP_BITSWAP_EN.
module tb_icap_word_packer;

  localparam logic [31:0] SYNC   = 32'hAA995566;
  localparam logic [31:0] CMD    = 32'h30008001;
  localparam logic [31:0] DESYNC = 32'h0000000D;

  logic        rclk = 1'b0;
  logic        rrst, en, rempty;
  logic [7:0]  rdata;
  logic        rinc, icap_csib, icap_rdwrb, synced, desync_done;
  logic [31:0] icap_i;
  logic [23:0] word_cnt;

  icap_word_packer dut (
    .rclk(rclk), .rrst(rrst), .en(en), .rdata(rdata), .rempty(rempty),
    .rinc(rinc), .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i),
    .synced(synced), .desync_done(desync_done), .word_cnt(word_cnt)
  );

  always #5 rclk = ~rclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_strobe = 0;
  int n_desync = 0;
  int strobe_cyc[$];

  logic [7:0]  fifo[$];
  // reference model state
  logic        m_synced, m_issued, m_des;
  logic [31:0] m_win, m_last, m_icap;
  logic [23:0] m_cnt;
  logic [7:0]  m_bytes[$];

  function automatic logic [31:0] out_form(input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef ICAP_BITSWAP_EN
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++)
        r[8*i+j] = w[8*i+7-j];
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_synced = 1'b0; m_issued = 1'b0; m_des = 1'b0;
    m_win = 32'h0; m_last = 32'h0; m_icap = 32'h0; m_cnt = 24'h0;
    m_bytes.delete();
  endtask

  task automatic model_issue(input logic [31:0] w);
    m_issued = 1'b1;
    m_last   = w;
    m_icap   = out_form(w);
    m_cnt    = m_cnt + 24'd1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (!m_synced) begin
      m_win = {m_win[23:0], b};
      if (m_win == SYNC) begin
        model_issue(SYNC);
        m_synced = 1'b1;
        m_bytes.delete();
      end
    end else begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        m_bytes.delete();
        if (w == DESYNC && m_last == CMD) begin
          m_des = 1'b1; m_synced = 1'b0; m_win = 32'h0;
        end
        model_issue(w);
      end
    end
  endtask

  task automatic step(input bit rnd, input bit rst);
    logic pop;
    rrst   = rst;
    en     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    rempty = (fifo.size() == 0) || (rnd && ($urandom_range(0, 2) == 0));
    rdata  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    pop    = en & ~rempty & ~rst;
    #1;
    chk("rinc", {31'd0, rinc}, {31'd0, pop});
    @(posedge rclk);
    cyc++;
    if (rst) model_reset();
    else begin
      m_issued = 1'b0; m_des = 1'b0;
      if (pop) model_byte(fifo.pop_front());
    end
    #1;
    chk("icap_csib",   {31'd0, icap_csib},   {31'd0, ~m_issued});
    chk("icap_rdwrb",  {31'd0, icap_rdwrb},  {31'd0, ~m_issued});
    chk("icap_i",      icap_i,               m_icap);
    chk("synced",      {31'd0, synced},      {31'd0, m_synced});
    chk("desync_done", {31'd0, desync_done}, {31'd0, m_des});
    chk("word_cnt",    {8'd0, word_cnt},     {8'd0, m_cnt});
    if (icap_csib === 1'b0) begin n_strobe++; strobe_cyc.push_back(cyc); end
    if (desync_done === 1'b1) n_desync++;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) fifo.push_back(w[8*i +: 8]);
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while (fifo.size() != 0 && n < 4000) begin
      step(rnd, 1'b0);
      n++;
    end
    chk("drain_timeout", fifo.size(), 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rrst = 1'b1; en = 1'b0; rempty = 1'b1; rdata = 8'h00;
    model_reset();
    @(posedge rclk); #1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Sync word preceded by junk
    n_strobe = 0;
    fifo.push_back(8'h00); fifo.push_back(8'hFF);
    push_word(SYNC);
    drain(1'b0);
    chk("sync_strobes", n_strobe, 32'd1);
    chk("sync_cnt", {8'd0, word_cnt}, 32'd1);
    chk("sync_synced", {31'd0, synced}, 32'd1);
`ifdef ICAP_BITSWAP_EN
    chk("sync_word", icap_i, 32'h5599AA66);
`else
    chk("sync_word", icap_i, 32'hAA995566);
`endif

    // Two back-to-back words, 4 cycles apart
    n_strobe = 0; strobe_cyc.delete();
    push_word(32'h20000000); push_word(CMD);
    drain(1'b0);
    chk("pair_strobes", n_strobe, 32'd2);
    if (strobe_cyc.size() == 2) chk("pair_spacing", strobe_cyc[1] - strobe_cyc[0], 32'd4);
    else chk("pair_spacing_count", strobe_cyc.size(), 32'd2);
`ifdef ICAP_BITSWAP_EN
    chk("pair_last", icap_i, 32'h0C000180);
`else
    chk("pair_last", icap_i, 32'h30008001);
`endif

    // DESYNC then stray word
    n_strobe = 0; n_desync = 0;
    push_word(DESYNC); push_word(32'h12345678);
    drain(1'b0);
    chk("desync_strobes", n_strobe, 32'd1);
    chk("desync_pulses", n_desync, 32'd1);
    chk("desync_synced", {31'd0, synced}, 32'd0);
    chk("desync_cnt", {8'd0, word_cnt}, 32'd4);

    // Byte-lane ordering / swap
    push_word(SYNC); push_word(32'h01020408);
    drain(1'b0);
`ifdef ICAP_BITSWAP_EN
    chk("lane_word", icap_i, 32'h80402010);
`else
    chk("lane_word", icap_i, 32'h01020408);
`endif
    chk("lane_cnt", {8'd0, word_cnt}, 32'd6);

    // Randomized stream with random en/rempty stalls
    push_word(CMD); push_word(DESYNC);
    for (int i = 0; i < 7; i++) fifo.push_back(8'($urandom_range(0, 255)));
    push_word(SYNC);
    for (int i = 0; i < 20; i++) push_word($urandom);
    push_word(CMD); push_word(DESYNC);
    for (int i = 0; i < 5; i++) fifo.push_back(8'($urandom_range(0, 255)));
    push_word(SYNC);
    for (int i = 0; i < 10; i++) push_word($urandom);
    drain(1'b1);
    chk("rand_cnt", {8'd0, word_cnt}, {8'd0, m_cnt});

    // Reset between 2nd and 3rd byte of a word
    fifo.push_back(8'hAB); fifo.push_back(8'hCD);
    drain(1'b0);
    step(1'b0, 1'b1);
    chk("rst_csib", {31'd0, icap_csib}, 32'd1);
    chk("rst_icap_i", icap_i, 32'd0);
    n_strobe = 0;
    fifo.push_back(8'hEF); fifo.push_back(8'h01);
    push_word(32'h11223344);
    drain(1'b0);
    chk("rst_nostrobe", n_strobe, 32'd0);
    push_word(SYNC);
    drain(1'b0);
    chk("rst_resync_strobes", n_strobe, 32'd1);
    chk("rst_resync_cnt", {8'd0, word_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
